// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Memory-side responder for the Chimpo multicycle datapath.
//             Services 16-bit word read/write requests after WAIT_CYCLES
//             wait states, flags misaligned or out-of-range accesses on
//             memerr and maps a single I/O word at IO_BASE.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK     in   1   system clock, rising edge
//    reset   in   1   asynchronous, active-high reset
//    req     in   1   request, held high by the initiator until ack
//    we      in   1   1 = write, 0 = read (sampled at accept)
//    addr    in  16   byte address, word index = addr[15:1]
//    wdata   in  16   write data (sampled at accept)
//    rdata   out 16   read data, valid in the ack cycle, held afterwards
//    ack     out  1   single-cycle completion strobe
//    memerr  out  1   error status of the last completed access
//    io_in   in  16   value returned for reads of IO_BASE
//    io_out  out 16   register loaded by writes to IO_BASE
//    io_we   out  1   one-cycle strobe on I/O write completion
// ============================================================================
module mem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] IO_BASE     = 16'hFF00
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ack,
   output logic        memerr,
   input  logic [15:0] io_in,
   output logic [15:0] io_out,
   output logic        io_we
);

   localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int          CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [16:0] RAM_LIMIT = 17'(2 * DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;

   logic [CW-1:0]   r_cnt;
   logic [15:0]     r_addr;
   logic [15:0]     r_wdata;
   logic            r_we;

   logic [15:0]     mem [0:DEPTH_WORDS-1];

   logic [15:0]     w_addr;
   logic            w_we;
   logic            w_is_io;
   logic            w_is_err;
   logic [AW-1:0]   w_idx;
   logic            w_enter_done;

   // The request being serviced: live inputs while IDLE (so a zero-wait
   // access can be decoded on its accept edge), latched copies afterwards.
   assign w_addr   = (r_state == IDLE) ? addr : r_addr;
   assign w_we     = (r_state == IDLE) ? we   : r_we;
   assign w_is_io  = (w_addr == IO_BASE);
   // High addresses other than the I/O word are rejected rather than
   // truncated, so they can never alias into the RAM.
   assign w_is_err = w_addr[0] | (({1'b0, w_addr} >= RAM_LIMIT) & ~w_is_io);
   assign w_idx    = w_addr[AW:1];

   assign w_enter_done = (w_next == DONE) && (r_state != DONE);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and strobes
   // ------------------------------------------------------------------
   always_comb begin
      w_next = r_state;
      ack    = 1'b0;
      io_we  = 1'b0;
      case (r_state)
         IDLE: begin
            if (req) begin
               w_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
            end
         end
         WAIT: begin
            // Counter was loaded with WAIT_CYCLES; leaving on 1 gives
            // exactly WAIT_CYCLES cycles in this state.
            if (r_cnt == CW'(1)) begin
               w_next = DONE;
            end
         end
         DONE: begin
            ack    = 1'b1;
            io_we  = w_we & w_is_io & ~w_is_err;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Request latch, wait counter and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_addr  <= 16'h0000;
         r_wdata <= 16'h0000;
         r_we    <= 1'b0;
         rdata   <= 16'h0000;
         memerr  <= 1'b0;
         io_out  <= 16'h0000;
      end else begin
         if (r_state == IDLE && req) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_we    <= we;
            r_cnt   <= CW'(WAIT_CYCLES);
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - CW'(1);
         end

         // Read data is fetched on the edge entering DONE so it is stable
         // for the whole ack cycle; writes leave rdata untouched.
         if (w_enter_done) begin
            memerr <= w_is_err;
            if (!w_we) begin
               if (w_is_err) begin
                  rdata <= 16'hDEAD;
               end else if (w_is_io) begin
                  rdata <= io_in;
               end else begin
                  rdata <= mem[w_idx];
               end
            end
         end

         if (r_state == DONE && w_we && w_is_io && !w_is_err) begin
            io_out <= r_wdata;
         end
      end
   end

   // ------------------------------------------------------------------
   // RAM write port (contents are not reset). An asynchronous reset
   // forces IDLE immediately, so an aborted access never commits.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (r_state == DONE && w_we && !w_is_err && !w_is_io) begin
         mem[w_idx] <= r_wdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_responder
//  Purpose  : Self-checking bench for mem_responder. Expected completions
//             are queued when a request is driven and compared when ack
//             appears; a second instance covers the zero-wait build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_responder;

   localparam int WAIT_CYCLES = 2;

   logic        clk;
   logic        reset;
   logic        req, we;
   logic [15:0] addr, wdata, io_in;
   logic [15:0] rdata, io_out;
   logic        ack, memerr, io_we;

   logic        req0, we0;
   logic [15:0] addr0, wdata0, io_in0;
   logic [15:0] rdata0, io_out0;
   logic        ack0, memerr0, io_we0;

   mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT_CYCLES), .IO_BASE(16'hFF00)) dut (
      .CLK(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .memerr(memerr), .io_in(io_in), .io_out(io_out),
      .io_we(io_we)
   );

   mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .IO_BASE(16'hFF00)) dut0 (
      .CLK(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
      .rdata(rdata0), .ack(ack0), .memerr(memerr0), .io_in(io_in0), .io_out(io_out0),
      .io_we(io_we0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      logic        io_wr;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [15:0] mem_model [int];
   logic [15:0] model_rdata = 16'h0000;
   logic        model_err   = 1'b0;
   logic [15:0] io_model    = 16'h0000;

   // Scoreboard consumer: every ack must match the oldest queued result.
   always @(negedge clk) begin
      if (ack) begin
         check("ack_has_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("rdata", rdata, mon_e.rdata);
            check("memerr", memerr, mon_e.err);
            check("io_we", io_we, mon_e.io_wr);
            model_rdata = mon_e.rdata;
            model_err   = mon_e.err;
         end
      end
   end

   function automatic exp_t predict(input logic w, input logic [15:0] a, input logic [15:0] d);
      exp_t e;
      logic err, io;
      err     = a[0] || ((a >= 16'h0800) && (a != 16'hFF00));
      io      = (a == 16'hFF00) && !err;
      e.err   = err;
      e.io_wr = w && io;
      if (w) begin
         e.rdata = model_rdata;
         if (io) io_model = d;
         else if (!err) mem_model[int'(a)] = d;
      end else begin
         e.rdata = err ? 16'hDEAD : (io ? io_in : mem_model[int'(a)]);
      end
      return e;
   endfunction

   // One complete access: queue the expectation, hold req for one edge,
   // then scramble the inputs (must be ignored) and wait for ack.
   task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d);
      int n;
      @(negedge clk);
      sb.push_back(predict(w, a, d));
      req = 1'b1; we = w; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = ~w; addr = a ^ 16'h0006; wdata = ~d;
      n = 1;
      while (!ack && n < 20) begin
         check("hold_memerr", memerr, model_err);
         check("hold_rdata", rdata, model_rdata);
         check("hold_io_we", io_we, 0);
         @(negedge clk);
         n++;
      end
      check("latency", n, WAIT_CYCLES + 1);
      @(negedge clk);
      check("ack_one_cycle", ack, 0);
      check("post_io_we", io_we, 0);
      check("post_memerr", memerr, model_err);
      check("io_out", io_out, io_model);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n, t1;
      reset = 1'b1;
      req = 0; we = 0; addr = 0; wdata = 0; io_in = 16'h0000;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; io_in0 = 16'h0000;
      repeat (2) @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_rdata", rdata, 16'h0000);
      check("rst_memerr", memerr, 0);
      check("rst_io_out", io_out, 16'h0000);
      check("rst_io_we", io_we, 0);
      reset = 1'b0;

      // Basic RAM write then read
      access(1'b1, 16'h0004, 16'hBEEF);
      access(1'b0, 16'h0004, 16'h0000);

      // Put some state in io_out before the reset test
      access(1'b1, 16'hFF00, 16'h0099);

      // Reset during WAIT aborts the write
      access(1'b1, 16'h0010, 16'hAAAA);
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'h1234;
      @(negedge clk);
      req = 1'b0;
      reset = 1'b1;
      #1;
      check("abort_ack", ack, 0);
      check("abort_rdata", rdata, 16'h0000);
      check("abort_memerr", memerr, 0);
      check("abort_io_out", io_out, 16'h0000);
      check("abort_io_we", io_we, 0);
      @(negedge clk);
      reset = 1'b0;
      model_rdata = 16'h0000; model_err = 1'b0; io_model = 16'h0000;
      repeat (4) begin
         @(negedge clk);
         check("abort_no_ack", ack, 0);
      end
      access(1'b0, 16'h0010, 16'h0000);

      // Misaligned read, memerr sticky until next good completion
      access(1'b0, 16'h0005, 16'h0000);
      access(1'b0, 16'h0004, 16'h0000);

      // Out-of-range write must not alias onto word 0
      access(1'b1, 16'h0000, 16'h1111);
      access(1'b1, 16'h0800, 16'h2222);
      access(1'b0, 16'h0000, 16'h0000);
      access(1'b1, 16'h07FE, 16'h3333);
      access(1'b0, 16'h07FE, 16'h0000);

      // I/O word
      access(1'b1, 16'hFF00, 16'h00C3);
      io_in = 16'h5A5A;
      access(1'b0, 16'hFF00, 16'h0000);
      access(1'b0, 16'hFF02, 16'h0000);

      // Back-to-back with req held high
      sb.push_back(predict(1'b0, 16'h0004, 16'h0000));
      sb.push_back(predict(1'b0, 16'h0000, 16'h0000));
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 16'h0004;
      n = 0;
      while (!ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("b2b_first_latency", n, WAIT_CYCLES + 1);
      t1 = cyc;
      addr = 16'h0000;
      @(negedge clk);
      check("b2b_idle_no_ack", ack, 0);
      @(negedge clk);
      req = 1'b0;
      n = 0;
      while (!ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("b2b_spacing", cyc - t1, WAIT_CYCLES + 2);
      repeat (4) @(negedge clk);

      // Zero-wait build: ack in the cycle after accept
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0002; wdata0 = 16'h7777;
      @(negedge clk);
      check("w0_write_ack", ack0, 1);
      check("w0_write_err", memerr0, 0);
      req0 = 1'b0;
      @(negedge clk);
      check("w0_ack_low", ack0, 0);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0002;
      @(negedge clk);
      check("w0_read_ack", ack0, 1);
      check("w0_read_rdata", rdata0, 16'h7777);
      req0 = 1'b0;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0003;
      @(negedge clk);
      check("w0_err_ack", ack0, 1);
      check("w0_err_memerr", memerr0, 1);
      check("w0_err_rdata", rdata0, 16'hDEAD);
      req0 = 1'b0;
      repeat (2) @(negedge clk);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
